// File: rtl/ldst_mem_server.sv
// ldst_mem_server
//   Memory-side responder for strided load/store accesses. One access at a
//   time: latch base/stride/length, pulse a grant, then walk local memory.
//   Loads return through a small credit-managed FIFO that honours requester
//   stall. Stores pass straight through to the memory write port.
//   Completion is a one-cycle O_Term pulse.
// Ports:
//   clock, reset                     clock, async active-low reset
//   I_Req/I_St/I_Length/I_Stride/I_Base  access request (held until granted)
//   O_Acceess_Grant                  one-cycle grant pulse
//   O_Valid/O_Data/I_Stall           load beat stream with back-pressure
//   I_Valid/I_Data/O_Stall           store beat stream
//   O_Term, O_Busy                   completion pulse, not-idle flag
//   O_Mem_Re/We/Addr/Data, I_Mem_Data  local memory port (1-cycle read)
module ldst_mem_server #(
  parameter int WIDTH_DATA = 32,
  parameter int WIDTH_ADDR = 12,
  parameter int DEPTH_BUFF = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  I_Req,
  input  logic                  I_St,
  input  logic [WIDTH_ADDR-1:0] I_Length,
  input  logic [WIDTH_ADDR-1:0] I_Stride,
  input  logic [WIDTH_ADDR-1:0] I_Base,
  output logic                  O_Acceess_Grant,
  output logic                  O_Valid,
  output logic [WIDTH_DATA-1:0] O_Data,
  input  logic                  I_Stall,
  input  logic                  I_Valid,
  input  logic [WIDTH_DATA-1:0] I_Data,
  output logic                  O_Stall,
  output logic                  O_Term,
  output logic                  O_Busy,
  output logic                  O_Mem_Re,
  output logic                  O_Mem_We,
  output logic [WIDTH_ADDR-1:0] O_Mem_Addr,
  output logic [WIDTH_DATA-1:0] O_Mem_Data,
  input  logic [WIDTH_DATA-1:0] I_Mem_Data
);

  localparam int PW = $clog2(DEPTH_BUFF);

  typedef enum logic [1:0] {IDLE, LOAD, STORE, TERM} state_t;

  state_t                               state;
  logic [WIDTH_ADDR-1:0]                addr_q, stride_q, remain_q;
  logic                                 grant_q;
  logic                                 inflight_q;
  logic [DEPTH_BUFF-1:0][WIDTH_DATA-1:0] buff_q;
  logic [PW-1:0]                        wp_q, rp_q;
  logic [PW:0]                          occ_q;

  logic        empty, pop, push, rd_issue, wr_take, last_beat;
  logic [PW:0] credit_used;

  assign empty       = (occ_q == '0);
  assign pop         = ~empty & ~I_Stall;
  // read data returns one cycle after issue and lands in the FIFO that edge
  assign push        = inflight_q;
  // credits count the FIFO plus the pending read; a same-cycle pop does not
  // free a credit, so the FIFO can never overflow
  assign credit_used = occ_q + {{PW{1'b0}}, inflight_q};
  assign rd_issue    = (state == LOAD) && (remain_q != '0) &&
                       (credit_used < (PW+1)'(DEPTH_BUFF));
  assign wr_take     = (state == STORE) && I_Valid;
  assign last_beat   = (remain_q == '0) && ~inflight_q &&
                       (occ_q == (PW+1)'(1)) && pop;

  assign O_Acceess_Grant = grant_q;
  assign O_Valid         = ~empty;
  assign O_Data          = empty ? '0 : buff_q[rp_q];
  assign O_Stall         = (state != STORE);
  assign O_Term          = (state == TERM);
  assign O_Busy          = (state != IDLE);
  assign O_Mem_Re        = rd_issue;
  assign O_Mem_We        = wr_take;
  assign O_Mem_Addr      = (rd_issue | wr_take) ? addr_q : '0;
  assign O_Mem_Data      = wr_take ? I_Data : '0;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      addr_q     <= '0;
      stride_q   <= '0;
      remain_q   <= '0;
      grant_q    <= 1'b0;
      inflight_q <= 1'b0;
      buff_q     <= '0;
      wp_q       <= '0;
      rp_q       <= '0;
      occ_q      <= '0;
    end else begin
      grant_q    <= 1'b0;
      inflight_q <= rd_issue;
      if (push) begin
        buff_q[wp_q] <= I_Mem_Data;
        wp_q         <= wp_q + PW'(1);
      end
      if (pop) rp_q <= rp_q + PW'(1);
      occ_q <= occ_q + (PW+1)'(push) - (PW+1)'(pop);
      // address wraps silently modulo 2^WIDTH_ADDR
      if (rd_issue | wr_take) begin
        addr_q   <= addr_q + stride_q;
        remain_q <= remain_q - WIDTH_ADDR'(1);
      end
      case (state)
        IDLE: if (I_Req) begin
          grant_q  <= 1'b1;
          addr_q   <= I_Base;
          stride_q <= I_Stride;
          remain_q <= I_Length;
          if (I_Length == '0) state <= TERM;
          else if (I_St)      state <= STORE;
          else                state <= LOAD;
        end
        LOAD:    if (last_beat) state <= TERM;
        STORE:   if (wr_take && remain_q == WIDTH_ADDR'(1)) state <= TERM;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ldst_mem_server.sv
module tb_ldst_mem_server;

  logic        clock = 1'b0;
  logic        reset;
  logic        I_Req, I_St, I_Stall, I_Valid;
  logic [11:0] I_Length, I_Stride, I_Base;
  logic [31:0] I_Data;
  logic [31:0] I_Mem_Data;
  logic        O_Acceess_Grant, O_Valid, O_Stall, O_Term, O_Busy;
  logic        O_Mem_Re, O_Mem_We;
  logic [31:0] O_Data, O_Mem_Data;
  logic [11:0] O_Mem_Addr;

  ldst_mem_server #(.WIDTH_DATA(32), .WIDTH_ADDR(12), .DEPTH_BUFF(4)) dut (
    .clock(clock), .reset(reset),
    .I_Req(I_Req), .I_St(I_St), .I_Length(I_Length), .I_Stride(I_Stride),
    .I_Base(I_Base), .O_Acceess_Grant(O_Acceess_Grant),
    .O_Valid(O_Valid), .O_Data(O_Data), .I_Stall(I_Stall),
    .I_Valid(I_Valid), .I_Data(I_Data), .O_Stall(O_Stall),
    .O_Term(O_Term), .O_Busy(O_Busy),
    .O_Mem_Re(O_Mem_Re), .O_Mem_We(O_Mem_We), .O_Mem_Addr(O_Mem_Addr),
    .O_Mem_Data(O_Mem_Data), .I_Mem_Data(I_Mem_Data)
  );

  always #5 clock = ~clock;

  // local memory model, one-cycle read latency
  logic [31:0] mem [0:4095];
  initial for (int n = 0; n < 4096; n++) mem[n] = n;
  always @(posedge clock) begin
    if (O_Mem_We) mem[O_Mem_Addr] <= O_Mem_Data;
    if (O_Mem_Re) I_Mem_Data <= mem[O_Mem_Addr];
  end

  // cycle counter and per-cycle output log (sampled mid-cycle)
  int cyc_n = 0;
  always @(posedge clock) cyc_n <= cyc_n + 1;

  bit          grant_l [0:1023];
  bit          term_l  [0:1023];
  bit          busy_l  [0:1023];
  bit          re_l    [0:1023];
  bit          we_l    [0:1023];
  bit          stall_l [0:1023];
  logic [11:0] addr_l  [0:1023];

  // transfer / credit / stall-hold monitor
  bit          mon_clr = 1'b0;
  logic [31:0] xq[$];
  int          issued, xfer, max_out, viol, hold_cnt;
  bit          prev_hold;
  logic [31:0] prev_data;

  always @(negedge clock) begin
    if (cyc_n < 1024) begin
      grant_l[cyc_n] = O_Acceess_Grant;
      term_l[cyc_n]  = O_Term;
      busy_l[cyc_n]  = O_Busy;
      re_l[cyc_n]    = O_Mem_Re;
      we_l[cyc_n]    = O_Mem_We;
      stall_l[cyc_n] = O_Stall;
      addr_l[cyc_n]  = O_Mem_Addr;
    end
    if (mon_clr) begin
      xq.delete();
      issued = 0; xfer = 0; max_out = 0; viol = 0; hold_cnt = 0;
      prev_hold = 1'b0; prev_data = '0;
    end else begin
      if (O_Mem_Re) issued++;
      if (issued - xfer > max_out) max_out = issued - xfer;
      if (prev_hold && (!O_Valid || O_Data !== prev_data)) viol++;
      prev_hold = O_Valid & I_Stall;
      prev_data = O_Data;
      if (prev_hold) hold_cnt++;
      if (O_Valid && !I_Stall) begin
        xq.push_back(O_Data);
        xfer++;
      end
    end
  end

  int n_vec = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic go_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_req(input logic [11:0] base, input logic [11:0] stride,
                           input logic [11:0] len, input logic st);
    I_Req = 1'b1; I_Base = base; I_Stride = stride; I_Length = len; I_St = st;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1, "watchdog");
  end

  int r, g, g2, cnt;

  initial begin
    reset = 1'b0; I_Req = 0; I_St = 0; I_Length = 0; I_Stride = 0; I_Base = 0;
    I_Stall = 0; I_Valid = 0; I_Data = 0;
    repeat (2) go_cycle();
    chk("rst_grant", O_Acceess_Grant, 0);
    chk("rst_valid", O_Valid, 0);
    chk("rst_data",  O_Data, 0);
    chk("rst_term",  O_Term, 0);
    chk("rst_busy",  O_Busy, 0);
    chk("rst_re_we", {O_Mem_Re, O_Mem_We}, 0);
    chk("rst_stall", O_Stall, 1);
    go_cycle(); reset = 1'b1;
    go_cycle();

    // plain load, stride 1
    go_cycle(); r = cyc_n; drive_req(12'h010, 12'd1, 12'd4, 1'b0);
    go_cycle(); g = cyc_n; I_Req = 0;
    repeat (10) go_cycle();
    chk("ld_grant_pre", grant_l[r], 0);
    chk("ld_grant", grant_l[g], 1);
    chk("ld_grant_post", grant_l[g+1], 0);
    for (int k = 0; k < 4; k++) begin
      chk("ld_re", re_l[g+k], 1);
      chk("ld_addr", addr_l[g+k], 12'h010 + k);
    end
    chk("ld_re_end", re_l[g+4], 0);
    chk("ld_term_early", term_l[g+5], 0);
    chk("ld_term", term_l[g+6], 1);
    chk("ld_term_once", term_l[g+7], 0);
    chk("ld_idle", busy_l[g+7], 0);

    // timed beat check: reissue and sample each beat cycle directly
    go_cycle(); drive_req(12'h010, 12'd1, 12'd4, 1'b0);
    go_cycle(); I_Req = 0;
    go_cycle(); chk("ld_nv_g1", O_Valid, 0);
    for (int k = 0; k < 4; k++) begin
      go_cycle();
      chk("ld_beat_v", O_Valid, 1);
      chk("ld_beat_d", O_Data, 32'h10 + k);
    end
    go_cycle(); chk("ld_nv_end", O_Valid, 0);
    repeat (3) go_cycle();

    // load with stall, stride 3
    go_cycle(); mon_clr = 1; drive_req(12'h010, 12'd3, 12'd6, 1'b0);
    go_cycle(); g = cyc_n; mon_clr = 0; I_Req = 0;
    for (int k = 1; k <= 20; k++) begin
      go_cycle();
      I_Stall = (k >= 3 && k <= 7);
    end
    I_Stall = 0;
    chk("st_nbeats", xq.size(), 6);
    for (int k = 0; k < 6 && k < xq.size(); k++) chk("stl_beat", xq[k], 32'h10 + 3*k);
    chk("stl_credit_max", max_out, 4);
    chk("stl_hold_viol", viol, 0);
    chk("stl_hold_cycles", hold_cnt, 5);
    chk("stl_term", term_l[g+13], 1);
    cnt = 0;
    for (int k = 0; k <= 20; k++) cnt += term_l[g+k];
    chk("stl_term_cnt", cnt, 1);

    // store with wrap and gapped valid
    go_cycle(); drive_req(12'hFFE, 12'd1, 12'd3, 1'b1);
    go_cycle(); g = cyc_n; I_Req = 0; I_Valid = 1; I_Data = 32'hA0;
    go_cycle(); I_Valid = 0; I_Data = 32'hDEAD;
    go_cycle(); I_Valid = 1; I_Data = 32'hB1;
    go_cycle(); I_Valid = 1; I_Data = 32'hC2;
    go_cycle(); I_Valid = 0; I_Data = 0;
    repeat (3) go_cycle();
    chk("st_mem_ffe", mem[12'hFFE], 32'hA0);
    chk("st_mem_fff", mem[12'hFFF], 32'hB1);
    chk("st_mem_000", mem[0], 32'hC2);
    chk("st_we_gap", we_l[g+1], 0);
    chk("st_addr0", addr_l[g], 12'hFFE);
    chk("st_addr2", addr_l[g+3], 12'h000);
    chk("st_stall_pre", stall_l[g-1], 1);
    for (int k = 0; k < 4; k++) chk("st_stall_low", stall_l[g+k], 0);
    chk("st_stall_post", stall_l[g+4], 1);
    chk("st_term_early", term_l[g+3], 0);
    chk("st_term", term_l[g+4], 1);

    // zero length
    go_cycle(); r = cyc_n; drive_req(12'h100, 12'd1, 12'd0, 1'b0);
    go_cycle(); g = cyc_n; I_Req = 0;
    repeat (4) go_cycle();
    chk("z_grant", grant_l[g], 1);
    chk("z_term", term_l[g], 1);
    chk("z_term_once", term_l[g+1], 0);
    chk("z_idle", busy_l[g+1], 0);
    cnt = 0;
    for (int k = r; k <= g + 2; k++) cnt += re_l[k] + we_l[k];
    chk("z_no_mem", cnt, 0);

    // reset mid-load after two beats
    go_cycle(); mon_clr = 1; drive_req(12'h020, 12'd1, 12'd8, 1'b0);
    go_cycle(); g = cyc_n; mon_clr = 0; I_Req = 0;
    repeat (4) go_cycle();
    reset = 1'b0; #1;
    chk("rm_beats", xq.size(), 2);
    chk("rm_valid", O_Valid, 0);
    chk("rm_data", O_Data, 0);
    chk("rm_busy", O_Busy, 0);
    chk("rm_stall", O_Stall, 1);
    chk("rm_re", O_Mem_Re, 0);
    repeat (3) go_cycle();
    cnt = 0;
    for (int k = g; k <= g + 7; k++) cnt += term_l[k];
    chk("rm_no_term", cnt, 0);
    reset = 1'b1;
    go_cycle(); mon_clr = 1; drive_req(12'h030, 12'd1, 12'd2, 1'b0);
    go_cycle(); g2 = cyc_n; mon_clr = 0; I_Req = 0;
    repeat (8) go_cycle();
    chk("rm2_grant", grant_l[g2], 1);
    chk("rm2_beats", xq.size(), 2);
    if (xq.size() == 2) begin
      chk("rm2_b0", xq[0], 32'h30);
      chk("rm2_b1", xq[1], 32'h31);
    end
    chk("rm2_term", term_l[g2+4], 1);

    // request held across access and TERM
    go_cycle(); drive_req(12'h040, 12'd1, 12'd2, 1'b0);
    go_cycle(); g = cyc_n;
    repeat (6) go_cycle();
    I_Req = 0;
    repeat (8) go_cycle();
    chk("h_grant1", grant_l[g], 1);
    cnt = 0;
    for (int k = g + 1; k <= g + 5; k++) cnt += grant_l[k];
    chk("h_no_regrant", cnt, 0);
    chk("h_term1", term_l[g+4], 1);
    chk("h_grant2", grant_l[g+6], 1);
    chk("h_grant2_once", grant_l[g+7], 0);
    chk("h_term2", term_l[g+10], 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
